// File: rtl/vc_rr_arbiter_pkg.sv
// Shared definitions for the VC round-robin arbiter: VC count, index type,
// one-hot FSM state encoding and the pointer-rotate helper.
package vc_rr_arbiter_pkg;

    localparam int NUM_VC = 4;
    localparam int VC_W   = 2;

    typedef logic [VC_W-1:0] vc_idx_t;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_BURST = 4'b0010,
        ST_HOLD  = 4'b0100,
        ST_ERR   = 4'b1000
    } state_e;

    // Round-robin successor; wraps 3 -> 0 through the 2-bit type.
    function automatic vc_idx_t next_vc(input vc_idx_t v);
        return v + vc_idx_t'(1);
    endfunction

endpackage

// File: rtl/vc_rr_pick.sv
// Combinational rotate-priority picker: first eligible VC scanning upward
// from ptr (mod NUM_VC).
module vc_rr_pick
    import vc_rr_arbiter_pkg::*;
(
    input  logic [NUM_VC-1:0] eligible,
    input  vc_idx_t           ptr,
    output logic              found,
    output vc_idx_t           idx
);

    vc_idx_t cand;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 0; k < NUM_VC; k++) begin
            cand = ptr + vc_idx_t'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/vc_rr_arbiter.sv
// Weighted round-robin scheduler draining four VC FIFOs into one output FIFO.
// Optional per-VC read statistics are compiled in with `define ARB_STATS_EN.
module vc_rr_arbiter
    import vc_rr_arbiter_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int WT_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enb,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_vc,
    input  logic [WT_W-1:0]          cfg_wt,
    input  logic [NUM_VC-1:0]        vc_empty,
    input  logic [NUM_VC-1:0]        continuar,
    input  logic                     out_almost_full,
    input  logic [NUM_VC-1:0]        error_full,
    input  logic [NUM_VC*DATA_W-1:0] vc_data,
    output logic [NUM_VC-1:0]        rd_en,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_wr,
    output logic [1:0]               grant_vc,
    output logic                     arb_err
`ifdef ARB_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [NUM_VC*16-1:0]     grant_cnt
`endif
);

    state_e            state_q, state_d;
    logic [WT_W-1:0]   cnt_q, cnt_d;
    vc_idx_t           grant_q, grant_d;
    vc_idx_t           ptr_q, ptr_d;
    logic [WT_W-1:0]   wt_q [NUM_VC];
    logic [WT_W-1:0]   wt_d [NUM_VC];
    logic              out_wr_q, out_wr_d;
    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] rd_en_c;
    logic              pick_found;
    vc_idx_t           pick_idx;

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            eligible[i] = !vc_empty[i] && (wt_q[i] != '0) && !continuar[i];
        end
    end

    vc_rr_pick u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        rd_en_c = '0;
        wt_d    = wt_q;

        if (cfg_we && !enb) begin
            wt_d[cfg_vc] = cfg_wt;
        end

        if (error_full != '0) begin
            state_d = ST_ERR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enb && pick_found) begin
                        rd_en_c[pick_idx] = 1'b1;
                        grant_d           = pick_idx;
                        cnt_d             = wt_q[pick_idx] - WT_W'(1);
                        // A weight-1 burst completes on the grant cycle itself.
                        if (wt_q[pick_idx] == WT_W'(1)) begin
                            ptr_d = next_vc(pick_idx);
                        end else begin
                            state_d = ST_BURST;
                        end
                    end
                end
                // HOLD behaves like BURST once almost_full clears, so both share one branch.
                ST_BURST, ST_HOLD: begin
                    if (enb && eligible[grant_q]) begin
                        if (out_almost_full) begin
                            state_d = ST_HOLD;
                        end else begin
                            rd_en_c[grant_q] = 1'b1;
                            cnt_d            = cnt_q - WT_W'(1);
                            if (cnt_q == WT_W'(1)) begin
                                state_d = ST_IDLE;
                                ptr_d   = next_vc(grant_q);
                            end else begin
                                state_d = ST_BURST;
                            end
                        end
                    end else begin
                        state_d = ST_IDLE;
                        ptr_d   = next_vc(grant_q);
                    end
                end
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_IDLE;
            endcase
        end

        out_wr_d = |rd_en_c;
    end

    // The asynchronous reset must silence the combinational read enables at once.
    assign rd_en = rst ? rd_en_c : '0;

    // NOTE: sequential state uses non-blocking assignments only; the small weight
    // table is reset because its power-up value (all ones) is architecturally visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            grant_q  <= '0;
            ptr_q    <= '0;
            out_wr_q <= 1'b0;
            for (int i = 0; i < NUM_VC; i++) begin
                wt_q[i] <= WT_W'(1);
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            out_wr_q <= out_wr_d;
            wt_q     <= wt_d;
        end
    end

    // grant_q still names the VC read last cycle, so it doubles as the data mux select.
    assign out_data = out_wr_q ? vc_data[int'(grant_q)*DATA_W +: DATA_W] : '0;
    assign out_wr   = out_wr_q;
    assign grant_vc = grant_q;
    assign arb_err  = (state_q == ST_ERR);

`ifdef ARB_STATS_EN
    logic [15:0] stat_q [NUM_VC];
    logic [15:0] stat_d [NUM_VC];

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            stat_d[i] = stat_q[i];
            if (stats_clr) begin
                stat_d[i] = '0;
            end else if (rd_en[i] && stat_q[i] != 16'hFFFF) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
            grant_cnt[i*16 +: 16] = stat_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_VC; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            stat_q <= stat_d;
        end
    end
`endif

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Directed self-checking bench for vc_rr_arbiter (default build, no statistics).
module tb_vc_rr_arbiter;

    logic        clk;
    logic        rst;
    logic        enb;
    logic        cfg_we;
    logic [1:0]  cfg_vc;
    logic [2:0]  cfg_wt;
    logic [3:0]  vc_empty;
    logic [3:0]  continuar;
    logic        out_almost_full;
    logic [3:0]  error_full;
    logic [23:0] vc_data;
    logic [3:0]  rd_en;
    logic [5:0]  out_data;
    logic        out_wr;
    logic [1:0]  grant_vc;
    logic        arb_err;

    int checks = 0;
    int errors = 0;

    vc_rr_arbiter #(.DATA_W(6), .WT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .enb             (enb),
        .cfg_we          (cfg_we),
        .cfg_vc          (cfg_vc),
        .cfg_wt          (cfg_wt),
        .vc_empty        (vc_empty),
        .continuar       (continuar),
        .out_almost_full (out_almost_full),
        .error_full      (error_full),
        .vc_data         (vc_data),
        .rd_en           (rd_en),
        .out_data        (out_data),
        .out_wr          (out_wr),
        .grant_vc        (grant_vc),
        .arb_err         (arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed word per VC: VC0=5, VC1=13, VC2=21, VC3=29.
    assign vc_data = {6'd29, 6'd21, 6'd13, 6'd5};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        next();
        enb = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic wr_wt(input logic [1:0] v, input logic [2:0] w);
        next();
        cfg_we = 1'b1;
        cfg_vc = v;
        cfg_wt = w;
        next();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b0; enb = 1'b0; cfg_we = 1'b0; cfg_vc = '0; cfg_wt = '0;
        vc_empty = 4'hF; continuar = '0; out_almost_full = 1'b0; error_full = '0;

        // Reset state
        next(); #1;
        check("rst_rd", rd_en, 4'b0000);
        check("rst_wr", out_wr, 1'b0);
        check("rst_data", out_data, 6'd0);
        check("rst_gnt", grant_vc, 2'd0);
        check("rst_err", arb_err, 1'b0);
        rst = 1'b1;

        // 1: unit weights, all non-empty -> 0,1,2,3,0, out_wr one clock later
        next(); enb = 1'b1; vc_empty = 4'h0; #1;
        check("t1_rd0", rd_en, 4'b0001);
        check("t1_wr0", out_wr, 1'b0);
        next(); #1;
        check("t1_rd1", rd_en, 4'b0010);
        check("t1_wr1", out_wr, 1'b1);
        check("t1_d1", out_data, 6'd5);
        next(); #1;
        check("t1_rd2", rd_en, 4'b0100);
        check("t1_d2", out_data, 6'd13);
        next(); #1;
        check("t1_rd3", rd_en, 4'b1000);
        check("t1_d3", out_data, 6'd21);
        next(); #1;
        check("t1_rd4", rd_en, 4'b0001);
        check("t1_d4", out_data, 6'd29);
        next(); enb = 1'b0; #1;
        check("t1_rd_off", rd_en, 4'b0000);
        check("t1_d5", out_data, 6'd5);
        next(); #1;
        check("t1_wr_off", out_wr, 1'b0);

        // 2: weights {3,1,0,2} -> 0,0,0,1,3,3,0
        rst_pulse();
        wr_wt(2'd0, 3'd3); wr_wt(2'd1, 3'd1); wr_wt(2'd2, 3'd0); wr_wt(2'd3, 3'd2);
        next(); enb = 1'b1; #1;
        check("t2_c0", rd_en, 4'b0001);
        next(); #1;
        check("t2_c1", rd_en, 4'b0001);
        next(); #1;
        check("t2_c2", rd_en, 4'b0001);
        next(); #1;
        check("t2_c3", rd_en, 4'b0010);
        next(); #1;
        check("t2_c4", rd_en, 4'b1000);
        check("t2_d4", out_data, 6'd13);
        next(); #1;
        check("t2_c5", rd_en, 4'b1000);
        check("t2_gnt5", grant_vc, 2'd3);
        next(); #1;
        check("t2_c6", rd_en, 4'b0001);
        check("t2_d6", out_data, 6'd29);
        next(); enb = 1'b0;

        // 3: VC1 (weight 4) empties after two reads -> burst ends, VC2 next
        rst_pulse();
        wr_wt(2'd1, 3'd4);
        next(); enb = 1'b1; vc_empty = 4'b0001; #1;
        check("t3_c0", rd_en, 4'b0010);
        next(); #1;
        check("t3_c1", rd_en, 4'b0010);
        next(); vc_empty = 4'b0011; #1;
        check("t3_c2", rd_en, 4'b0000);
        check("t3_d2", out_data, 6'd13);
        next(); #1;
        check("t3_c3", rd_en, 4'b0100);
        next(); enb = 1'b0; vc_empty = 4'h0; #1;
        check("t3_d4", out_data, 6'd21);

        // 4: almost_full for 3 cycles mid-burst of weight 4
        rst_pulse();
        wr_wt(2'd0, 3'd4);
        next(); enb = 1'b1; #1;
        check("t4_c0", rd_en, 4'b0001);
        next(); #1;
        check("t4_c1", rd_en, 4'b0001);
        next(); out_almost_full = 1'b1; #1;
        check("t4_h0", rd_en, 4'b0000);
        check("t4_h0_wr", out_wr, 1'b1);
        next(); #1;
        check("t4_h1", rd_en, 4'b0000);
        check("t4_h1_wr", out_wr, 1'b0);
        next(); #1;
        check("t4_h2", rd_en, 4'b0000);
        next(); out_almost_full = 1'b0; #1;
        check("t4_r0", rd_en, 4'b0001);
        check("t4_gnt", grant_vc, 2'd0);
        next(); #1;
        check("t4_r1", rd_en, 4'b0001);
        next(); #1;
        check("t4_next", rd_en, 4'b0010);
        next(); enb = 1'b0;

        // 5: error_full during BURST -> ERR, in-flight word still written
        rst_pulse();
        wr_wt(2'd0, 3'd3);
        next(); enb = 1'b1; #1;
        check("t5_c0", rd_en, 4'b0001);
        next(); #1;
        check("t5_c1", rd_en, 4'b0001);
        next(); error_full = 4'b0100; #1;
        check("t5_inflight_wr", out_wr, 1'b1);
        check("t5_inflight_d", out_data, 6'd5);
        next(); error_full = 4'b0000; #1;
        check("t5_rd_err", rd_en, 4'b0000);
        check("t5_err", arb_err, 1'b1);
        check("t5_wr_err", out_wr, 1'b0);
        next(); #1;
        check("t5_rd_err2", rd_en, 4'b0000);
        check("t5_err_sticky", arb_err, 1'b1);
        next(); rst = 1'b0; #1;
        check("t5_err_clr", arb_err, 1'b0);
        #1; enb = 1'b0; rst = 1'b1;

        // 6: cfg_we while enabled is ignored; async reset mid-burst
        next(); enb = 1'b1; cfg_we = 1'b1; cfg_vc = 2'd0; cfg_wt = 3'd5; #1;
        check("t6_c0", rd_en, 4'b0001);
        next(); cfg_we = 1'b0; #1;
        check("t6_c1", rd_en, 4'b0010);
        next(); #1;
        check("t6_c2", rd_en, 4'b0100);
        next(); #1;
        check("t6_c3", rd_en, 4'b1000);
        next(); #1;
        check("t6_c4", rd_en, 4'b0001);
        next(); #1;
        check("t6_wt_kept", rd_en, 4'b0010);
        next(); enb = 1'b0; cfg_we = 1'b1; cfg_vc = 2'd3; cfg_wt = 3'd4; #1;
        check("t6_off", rd_en, 4'b0000);
        next(); cfg_we = 1'b0; enb = 1'b1; #1;
        check("t6_c7", rd_en, 4'b0100);
        next(); #1;
        check("t6_c8", rd_en, 4'b1000);
        next(); #1;
        check("t6_c9", rd_en, 4'b1000);
        check("t6_gnt9", grant_vc, 2'd3);
        #1; rst = 1'b0; #1;
        check("t6_arst_rd", rd_en, 4'b0000);
        check("t6_arst_wr", out_wr, 1'b0);
        check("t6_arst_d", out_data, 6'd0);
        check("t6_arst_gnt", grant_vc, 2'd0);
        check("t6_arst_err", arb_err, 1'b0);
        next(); rst = 1'b1; #1;
        check("t6_after_rst", rd_en, 4'b0001);
        next(); enb = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
